// File: rtl/sonic_sync_pack_2_128_pkg.sv
// Constants shared by the Rx sync-header packer and the Tx sync-header ring.
package sonic_sync_pkg;
    localparam int unsigned SYNC_WIDTH     = 2;
    localparam int unsigned WORD_WIDTH     = 128;
    localparam int unsigned SLOTS_PER_WORD = 64;
    localparam int unsigned SLOT_BITS      = 6;
    localparam int unsigned FILL_BITS      = SLOT_BITS + 1;
    localparam int unsigned DROP_BITS      = 16;
endpackage

// File: rtl/sonic_sync_pack_2_128_if.sv
// Packer bus: Rx sync headers in, ring write port and occupancy status out.
// flush / flush_slots exist only when SONIC_SYNC_PACK_FLUSH_EN is defined.
interface sonic_sync_pack_2_128_if #(
    parameter int unsigned ADDR_WIDTH = 9
);
    import sonic_sync_pkg::*;

    logic                  enable;
    logic [SYNC_WIDTH-1:0] data_in;
    logic                  data_valid;
    logic [ADDR_WIDTH:0]   rd_ptr;
    logic                  ovf_clear;
    logic [WORD_WIDTH-1:0] data_out;
    logic                  wren;
    logic [ADDR_WIDTH-1:0] wr_address;
    logic [ADDR_WIDTH:0]   wr_ptr;
    logic                  full;
    logic                  overflow;
    logic [DROP_BITS-1:0]  drop_count;
`ifdef SONIC_SYNC_PACK_FLUSH_EN
    logic                  flush;
    logic [FILL_BITS-1:0]  flush_slots;

    modport master (
        output enable, data_in, data_valid, rd_ptr, ovf_clear, flush,
        input  data_out, wren, wr_address, wr_ptr, full, overflow, drop_count, flush_slots
    );
    modport slave (
        input  enable, data_in, data_valid, rd_ptr, ovf_clear, flush,
        output data_out, wren, wr_address, wr_ptr, full, overflow, drop_count, flush_slots
    );
`else
    modport master (
        output enable, data_in, data_valid, rd_ptr, ovf_clear,
        input  data_out, wren, wr_address, wr_ptr, full, overflow, drop_count
    );
    modport slave (
        input  enable, data_in, data_valid, rd_ptr, ovf_clear,
        output data_out, wren, wr_address, wr_ptr, full, overflow, drop_count
    );
`endif
endinterface

// File: rtl/sonic_sync_pack_2_128_ring_wr_ptr.sv
// Host ring write pointer, full detection and overflow / drop accounting.
module sonic_ring_wr_ptr
    import sonic_sync_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 9
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 wren,
    input  logic                 drop,
    input  logic                 ovf_clear,
    input  logic [ADDR_WIDTH:0]  rd_ptr,
    output logic [ADDR_WIDTH:0]  wr_ptr,
    output logic [ADDR_WIDTH:0]  commit_ptr,
    output logic                 full,
    output logic                 commit_full,
    output logic                 overflow,
    output logic [DROP_BITS-1:0] drop_count
);
    localparam logic [ADDR_WIDTH:0] DEPTH_PTR = {1'b1, {ADDR_WIDTH{1'b0}}};

    // commit_ptr also counts a write still in flight, so an emit decision made
    // while wren is high never reuses the address being written.
    assign commit_ptr  = wr_ptr + {{ADDR_WIDTH{1'b0}}, wren};
    assign full        = (wr_ptr - rd_ptr) == DEPTH_PTR;
    assign commit_full = (commit_ptr - rd_ptr) == DEPTH_PTR;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
        end else begin
            wr_ptr <= commit_ptr;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (ovf_clear) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_count != '1) begin
                drop_count <= drop_count + DROP_BITS'(1);
            end
        end
    end
endmodule

// File: rtl/sonic_sync_pack_2_128.sv
// Packs 64 Rx sync headers per 128-bit word and writes them to the host ring.
// Partial-word flush is built only when SONIC_SYNC_PACK_FLUSH_EN is defined.
module sonic_sync_pack_2_128
    import sonic_sync_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 9
) (
    input logic                    clock,
    input logic                    reset_n,
    sonic_sync_pack_2_128_if.slave bus
);
    logic [SLOT_BITS-1:0]  slot;
    logic [WORD_WIDTH-1:0] accum;
    logic [WORD_WIDTH-1:0] merged;
    logic                  take;
    logic                  word_done;
    logic                  emit;
    logic                  accept;
    logic                  drop;
    logic [WORD_WIDTH-1:0] data_q;
    logic                  wren_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH:0]   wr_ptr;
    logic [ADDR_WIDTH:0]   commit_ptr;
    logic                  full;
    logic                  commit_full;
    logic                  overflow;
    logic [DROP_BITS-1:0]  drop_count;
`ifdef SONIC_SYNC_PACK_FLUSH_EN
    logic [FILL_BITS-1:0]  fill;
    logic [FILL_BITS-1:0]  fill_q;
`endif

    always_comb begin
        take   = bus.enable && bus.data_valid;
        merged = accum;
        if (take) begin
            merged[{slot, 1'b0} +: SYNC_WIDTH] = bus.data_in;
        end
        word_done = take && (slot == SLOT_BITS'(SLOTS_PER_WORD - 1));
`ifdef SONIC_SYNC_PACK_FLUSH_EN
        // A header arriving with flush is counted before the flush is judged.
        fill = {1'b0, slot} + FILL_BITS'(take);
        emit = word_done || (bus.enable && bus.flush && (fill != '0));
`else
        emit = word_done;
`endif
        accept = emit && !commit_full;
        drop   = emit && commit_full;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            slot  <= '0;
            accum <= '0;
        end else if (!bus.enable || emit) begin
            slot  <= '0;
            accum <= '0;
        end else if (take) begin
            slot  <= slot + SLOT_BITS'(1);
            accum <= merged;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wren_q <= 1'b0;
            data_q <= '0;
            addr_q <= '0;
        end else begin
            wren_q <= accept;
            if (accept) begin
                data_q <= merged;
                addr_q <= commit_ptr[ADDR_WIDTH-1:0];
            end
        end
    end

`ifdef SONIC_SYNC_PACK_FLUSH_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fill_q <= '0;
        end else if (accept) begin
            fill_q <= fill;
        end
    end

    assign bus.flush_slots = fill_q;
`endif

    sonic_ring_wr_ptr #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_wr_ptr (
        .clock       (clock),
        .reset_n     (reset_n),
        .wren        (wren_q),
        .drop        (drop),
        .ovf_clear   (bus.ovf_clear),
        .rd_ptr      (bus.rd_ptr),
        .wr_ptr      (wr_ptr),
        .commit_ptr  (commit_ptr),
        .full        (full),
        .commit_full (commit_full),
        .overflow    (overflow),
        .drop_count  (drop_count)
    );

    assign bus.data_out   = data_q;
    assign bus.wren       = wren_q;
    assign bus.wr_address = addr_q;
    assign bus.wr_ptr     = wr_ptr;
    assign bus.full       = full;
    assign bus.overflow   = overflow;
    assign bus.drop_count = drop_count;
endmodule
